// File: rtl/rtc_read_cycle.sv
// rtc_read_cycle: sequences one RTC data-phase read on the multiplexed bus.
// SETUP -> ASSERT (CS/RD low) -> SAMPLE (capture byte) -> HOLD -> RECOVER -> DONE.
//
// Ports:
//   clk      system clock, rising edge
//   reset    asynchronous active-low reset
//   start    request one read cycle (only honoured in IDLE)
//   rtc_din  RTC data bus from the pads
//   acs      RTC chip select, active low
//   ard      RTC read strobe, active low
//   awr      RTC write strobe, active low (always 1 here)
//   aad      address/data select, 1 = data phase (always 1 here)
//   bus_oe   data bus pad drive enable (always 0, bus released)
//   rdata    captured byte, stable until the next capture or reset
//   busy     high in every state except IDLE
//   done     one-cycle completion pulse
//
// Build option RTC_READ_SYNC_EN: rtc_din passes through a 2-flop synchronizer
// and ASSERT is stretched by 2 cycles to cover the synchronizer delay.
module rtc_read_cycle #(
  parameter int unsigned T_SETUP   = 10,
  parameter int unsigned T_ACCESS  = 10,
  parameter int unsigned T_HOLD    = 2,
  parameter int unsigned T_RECOVER = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] rtc_din,
  output logic       acs,
  output logic       ard,
  output logic       awr,
  output logic       aad,
  output logic       bus_oe,
  output logic [7:0] rdata,
  output logic       busy,
  output logic       done
);

  // A zero duration is treated as one cycle.
  localparam int unsigned SETUP_N   = (T_SETUP   == 0) ? 1 : T_SETUP;
  localparam int unsigned HOLD_N    = (T_HOLD    == 0) ? 1 : T_HOLD;
  localparam int unsigned RECOVER_N = (T_RECOVER == 0) ? 1 : T_RECOVER;
`ifdef RTC_READ_SYNC_EN
  // ASSERT can reach 65 cycles, so the counter needs one extra bit.
  localparam int unsigned ACCESS_N  = ((T_ACCESS == 0) ? 1 : T_ACCESS) + 2;
  localparam int unsigned CNT_W     = 7;
`else
  localparam int unsigned ACCESS_N  = (T_ACCESS == 0) ? 1 : T_ACCESS;
  localparam int unsigned CNT_W     = 6;
`endif

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_SETUP   = 3'd1;
  localparam logic [2:0] ST_ASSERT  = 3'd2;
  localparam logic [2:0] ST_SAMPLE  = 3'd3;
  localparam logic [2:0] ST_HOLD    = 3'd4;
  localparam logic [2:0] ST_RECOVER = 3'd5;
  localparam logic [2:0] ST_DONE    = 3'd6;

  localparam logic [CNT_W-1:0] SETUP_LAST   = CNT_W'(SETUP_N - 1);
  localparam logic [CNT_W-1:0] ACCESS_LAST  = CNT_W'(ACCESS_N - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLD_N - 1);
  localparam logic [CNT_W-1:0] RECOVER_LAST = CNT_W'(RECOVER_N - 1);

  logic [2:0]       state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             acs_nx, ard_nx, busy_nx, done_nx;
  logic [7:0]       rdata_nx;
  logic [7:0]       din_s;

  // The write path and pad driver are never used by a read cycle.
  assign awr    = 1'b1;
  assign bus_oe = 1'b0;
  assign aad    = 1'b1;

`ifdef RTC_READ_SYNC_EN
  logic [7:0] sync_q1, sync_q2;

  // Two-flop synchronizer on the asynchronous RTC data bus.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q1 <= 8'h00;
      sync_q2 <= 8'h00;
    end else begin
      sync_q1 <= rtc_din;
      sync_q2 <= sync_q1;
    end
  end
  assign din_s = sync_q2;
`else
  assign din_s = rtc_din;
`endif

  // State, phase counter and registered pin outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
      acs   <= 1'b1;
      ard   <= 1'b1;
      busy  <= 1'b0;
      done  <= 1'b0;
      rdata <= 8'h00;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      acs   <= acs_nx;
      ard   <= ard_nx;
      busy  <= busy_nx;
      done  <= done_nx;
      rdata <= rdata_nx;
    end
  end

  // Next state, counter, and outputs decoded from the next state so the
  // registered pins line up with the state they belong to.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt + CNT_W'(1);
    acs_nx   = 1'b1;
    ard_nx   = 1'b1;
    busy_nx  = 1'b1;
    done_nx  = 1'b0;
    rdata_nx = rdata;

    case (state)
      ST_IDLE: begin
        cnt_nx = '0;
        if (start) state_nx = ST_SETUP;
      end
      ST_SETUP: begin
        if (cnt == SETUP_LAST) begin
          state_nx = ST_ASSERT;
          cnt_nx   = '0;
        end
      end
      ST_ASSERT: begin
        if (cnt == ACCESS_LAST) begin
          state_nx = ST_SAMPLE;
          cnt_nx   = '0;
        end
      end
      ST_SAMPLE: begin
        rdata_nx = din_s;
        state_nx = ST_HOLD;
        cnt_nx   = '0;
      end
      ST_HOLD: begin
        if (cnt == HOLD_LAST) begin
          state_nx = ST_RECOVER;
          cnt_nx   = '0;
        end
      end
      ST_RECOVER: begin
        if (cnt == RECOVER_LAST) begin
          state_nx = ST_DONE;
          cnt_nx   = '0;
        end
      end
      ST_DONE: begin
        state_nx = ST_IDLE;
        cnt_nx   = '0;
      end
      default: begin
        state_nx = ST_IDLE;
        cnt_nx   = '0;
      end
    endcase

    case (state_nx)
      ST_IDLE:              busy_nx = 1'b0;
      ST_ASSERT, ST_SAMPLE: begin
        acs_nx = 1'b0;
        ard_nx = 1'b0;
      end
      ST_HOLD:              acs_nx = 1'b0;
      ST_DONE:              done_nx = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_rtc_read_cycle.sv
// Self-checking bench for rtc_read_cycle: a timeline model (offsets from the
// accepting edge) checked every cycle, plus literal edge-by-edge expectations.
module tb_rtc_read_cycle;

`ifdef RTC_READ_SYNC_EN
  localparam int SX = 2;
`else
  localparam int SX = 0;
`endif
  // Phase lengths with default parameters; A includes the sync stretch.
  localparam int S = 10;
  localparam int A = 10 + SX;
  localparam int H = 2;
  localparam int R = 10;
  localparam int TOTAL = S + A + 1 + H + R;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [7:0] rtc_din = 8'h00;
  logic       acs, ard, awr, aad, bus_oe, busy, done;
  logic [7:0] rdata;

  int tests = 0;
  int fails = 0;
  int done_cnt = 0;
  bit chk_en = 1'b0;

  rtc_read_cycle dut (
    .clk(clk), .reset(reset), .start(start), .rtc_din(rtc_din),
    .acs(acs), .ard(ard), .awr(awr), .aad(aad), .bus_oe(bus_oe),
    .rdata(rdata), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests = tests + 1;
    if (act !== exp) begin
      fails = fails + 1;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: ecnt counts edges out of reset; a cycle accepted at edge k is
  // described purely by the offset d = ecnt - k.
  int         ecnt = 0;
  int         k = 0;
  bit         active = 1'b0;
  logic [7:0] exp_rdata = 8'h00;
  logic [7:0] h1 = 8'h00, h2 = 8'h00;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      active    <= 1'b0;
      exp_rdata <= 8'h00;
      h1        <= 8'h00;
      h2        <= 8'h00;
    end else begin
      ecnt <= ecnt + 1;
      h1   <= rtc_din;
      h2   <= h1;
      if (active) begin
        if (ecnt + 1 == k + S + A + 1) exp_rdata <= (SX != 0) ? h2 : rtc_din;
        if (ecnt + 1 == k + TOTAL + 1) active <= 1'b0;
      end else if (start) begin
        active <= 1'b1;
        k      <= ecnt + 1;
      end
    end
  end

  // Per-cycle comparison against the model.
  always begin
    int d;
    logic e_acs, e_ard, e_busy, e_done;
    @(negedge clk);
    d = ecnt - k;
    e_acs = 1'b1; e_ard = 1'b1; e_busy = 1'b0; e_done = 1'b0;
    if (reset && active) begin
      e_busy = 1'b1;
      if (d >= S && d <= S + A) begin
        e_acs = 1'b0; e_ard = 1'b0;
      end else if (d > S + A && d <= S + A + H) begin
        e_acs = 1'b0;
      end
      if (d == TOTAL) e_done = 1'b1;
    end
    if (done === 1'b1) done_cnt = done_cnt + 1;
    if (chk_en) begin
      chk("acs", 32'(acs), 32'(e_acs));
      chk("ard", 32'(ard), 32'(e_ard));
      chk("busy", 32'(busy), 32'(e_busy));
      chk("done", 32'(done), 32'(e_done));
      chk("rdata", 32'(rdata), 32'(exp_rdata));
      chk("awr_high", 32'(awr), 32'd1);
      chk("bus_oe_low", 32'(bus_oe), 32'd0);
      chk("aad_high", 32'(aad), 32'd1);
      if (ard === 1'b0 && acs !== 1'b0) chk("ard_without_acs", 32'(acs), 32'd0);
    end
  end

  // Wait until the cycle visible after edge e (sampled at the falling edge).
  task automatic wait_to(input int e);
    while (ecnt < e) @(negedge clk);
  endtask

  task automatic pulse_start(output int kk);
    @(negedge clk); #1;
    start = 1'b1;
    kk = ecnt + 1;
    @(negedge clk); #1;
    start = 1'b0;
  endtask

  initial begin
    int kk, dc;
    #600000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int kk, dc;
    // Reset check
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    chk("rst_acs", 32'(acs), 32'd1);
    chk("rst_rdata", 32'(rdata), 32'h00);
    #1 reset = 1'b1;
    repeat (50) @(negedge clk);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_ard", 32'(ard), 32'd1);

    // Single read
    rtc_din = 8'hA5;
    pulse_start(kk);
    wait_to(kk + 9);       chk("setup_acs", 32'(acs), 32'd1);
    wait_to(kk + 10);      chk("acs_fall", 32'(acs), 32'd0);
                           chk("ard_fall", 32'(ard), 32'd0);
    wait_to(kk + 20 + SX); chk("sample_ard", 32'(ard), 32'd0);
    wait_to(kk + 21 + SX); chk("ard_rise", 32'(ard), 32'd1);
                           chk("hold_acs", 32'(acs), 32'd0);
                           chk("rdata_a5", 32'(rdata), 32'hA5);
    wait_to(kk + 23 + SX); chk("acs_rise", 32'(acs), 32'd1);
    wait_to(kk + 32 + SX); chk("done_early", 32'(done), 32'd0);
    wait_to(kk + 33 + SX); chk("done_pulse", 32'(done), 32'd1);
    wait_to(kk + 34 + SX); chk("done_end", 32'(done), 32'd0);
                           chk("busy_end", 32'(busy), 32'd0);

    // Sample point: data changes just before SAMPLE's closing edge
    repeat (3) @(negedge clk);
    rtc_din = 8'h3C;
    pulse_start(kk);
    wait_to(kk + 20); #1 rtc_din = 8'hC3;
    wait_to(kk + 33 + SX); chk("done_sp", 32'(done), 32'd1);
                           chk("rdata_c3", 32'(rdata), 32'hC3);

    // Data changing only after the capture edge is not seen
    repeat (3) @(negedge clk);
    rtc_din = 8'h77;
    pulse_start(kk);
    wait_to(kk + 21 + SX); #1 rtc_din = 8'h88;
    wait_to(kk + 34 + SX); chk("rdata_late", 32'(rdata), 32'h77);

    // Busy filtering: second start while busy is ignored
    repeat (3) @(negedge clk);
    rtc_din = 8'h5A;
    dc = done_cnt;
    pulse_start(kk);
    wait_to(kk + 14); #1 start = 1'b1;
    @(negedge clk); #1 start = 1'b0;
    wait_to(kk + 80);
    chk("one_done", 32'(done_cnt - dc), 32'd1);
    chk("no_relaunch", 32'(busy), 32'd0);

    // Reset inside ASSERT
    rtc_din = 8'hE7;
    dc = done_cnt;
    pulse_start(kk);
    wait_to(kk + 14);
    chk("pre_rst_acs", 32'(acs), 32'd0);
    #2 reset = 1'b0;
    #1;
    chk("rst_mid_acs", 32'(acs), 32'd1);
    chk("rst_mid_ard", 32'(ard), 32'd1);
    chk("rst_mid_rdata", 32'(rdata), 32'h00);
    repeat (4) @(negedge clk);
    #1 reset = 1'b1;
    repeat (40) @(negedge clk);
    chk("rst_no_done", 32'(done_cnt - dc), 32'd0);
    pulse_start(kk);
    wait_to(kk + 33 + SX); chk("post_rst_done", 32'(done), 32'd1);
                           chk("post_rst_rdata", 32'(rdata), 32'hE7);

    // Back-to-back with start held high
    repeat (3) @(negedge clk);
    rtc_din = 8'h11;
    #1 start = 1'b1;
    kk = ecnt + 1;
    wait_to(kk + 22 + SX); #1 rtc_din = 8'h22;
    wait_to(kk + 33 + SX); chk("b2b_done1", 32'(done), 32'd1);
                           chk("b2b_rdata1", 32'(rdata), 32'h11);
    wait_to(kk + 34 + SX); chk("b2b_gap_idle", 32'(busy), 32'd0);
    wait_to(kk + 67 + 2*SX); chk("b2b_not_yet", 32'(done), 32'd0);
    wait_to(kk + 68 + 2*SX); chk("b2b_done2", 32'(done), 32'd1);
                             chk("b2b_rdata2", 32'(rdata), 32'h22);
    #1 start = 1'b0;
    repeat (80) @(negedge clk);
    chk("b2b_idle", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rtc_read_cycle.md
Name: rtc_read_cycle

Overview:
- Bus-cycle sequencer that reads one data byte from the RTC over its multiplexed address/data bus.
- It is the read-side counterpart of the address-write sequencer: that block latches the register address, then this block runs the data-phase read strobe and captures the byte the RTC drives.
- Sits between the top-level control FSM (start/done handshake) and the RTC pins (acs, ard, awr, aad, data bus).

Parameters:
- T_SETUP, 10, cycles with aad=1 and strobes high before CS/RD assert (1..63; 0 treated as 1).
- T_ACCESS, 10, cycles acs=0/ard=0 before the data bus is sampled (1..63; 0 treated as 1).
- T_HOLD, 2, cycles acs=0 with ard=1 after sampling (1..63; 0 treated as 1).
- T_RECOVER, 10, cycles with all strobes high before done (1..63; 0 treated as 1).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  request one read cycle; sampled only in IDLE.
- rtc_din  input  8  RTC data bus as seen from pads.
- acs  output  1  RTC chip select, active low.
- ard  output  1  RTC read strobe, active low.
- awr  output  1  RTC write strobe, active low; held 1 by this block.
- aad  output  1  RTC address/data select; 1 = data phase.
- bus_oe  output  1  pad drive enable for the data bus; held 0 (bus released).
- rdata  output  8  captured byte.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse when the cycle completes.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, internal counter=0.
- Reset values: acs=1, ard=1, awr=1, aad=1, bus_oe=0, rdata=8'h00, busy=0, done=0.
- All outputs are registered with no combinational paths to pins. One 6-bit phase counter clears on every state entry.
- IDLE: strobes high, aad=1. If start=1 on a clock edge, the next state is SETUP.
- SETUP: acs=1, ard=1, aad=1 for T_SETUP cycles, then ASSERT.
- ASSERT: acs=0, ard=0, aad=1 for T_ACCESS cycles, then SAMPLE.
- SAMPLE: acs=0, ard=0 for one cycle. rdata<=rtc_din on the edge that leaves SAMPLE. Then HOLD.
- HOLD: acs=0, ard=1 for T_HOLD cycles, then RECOVER.
- RECOVER: acs=1, ard=1, aad=1 for T_RECOVER cycles, then DONE.
- DONE: done=1 for exactly one cycle, then IDLE. start is ignored in DONE.
- Latency: start accepted at edge k puts DONE in cycle k+1+T_SETUP+T_ACCESS+1+T_HOLD+T_RECOVER (k+34 with defaults).
- rdata is valid from the edge after SAMPLE and is stable until the next SAMPLE or reset.
- start while busy=1 is ignored and never queued. start held high continuously launches back-to-back cycles separated by one IDLE cycle.
- Reset mid-cycle releases the strobes immediately (acs/ard=1). rdata clears to 8'h00 and no done pulse is issued.
- awr stays 1 and bus_oe stays 0 in every state. Asserting either is a design error, and the bench asserts on it.
- ard never goes low while acs=1. acs never rises while ard=0.

Optional Feature:
- RTC_READ_SYNC_EN defined:
  - rtc_din passes through a 2-flop synchronizer clocked by clk.
  - ASSERT lasts T_ACCESS+2 cycles.
  - SAMPLE captures the synchronizer output.
  - Total latency increases by 2 (k+36 with defaults).
- RTC_READ_SYNC_EN undefined: rtc_din is sampled directly in SAMPLE, with the latency given above.

Test Plan:
- Reset check: reset=0 then release with start=0 -> acs=ard=awr=aad=1, rdata=00, busy=0, done=0, and these hold for 50 cycles.
- Single read: rtc_din=8'hA5 held, start pulsed at edge k -> acs falls at k+11, ard falls at k+11 and rises at k+22, acs rises at k+24, rdata=A5 from k+22, done=1 only in cycle k+34.
- Sample point: rtc_din=8'h3C until k+20, then 8'hC3 -> rdata=C3, proving capture at the end of SAMPLE. With RTC_READ_SYNC_EN, done moves to k+36.
- Busy filtering: second start pulse at k+15 -> ignored, exactly one done pulse, no second strobe sequence.
- Reset mid-cycle: reset=0 at k+15 (inside ASSERT) -> acs/ard=1 asynchronously, rdata=00, no done. A new start after release completes normally.
- Back-to-back: start held high, rtc_din 8'h11 then 8'h22 -> two done pulses 35 cycles apart, rdata 11 then 22, awr=1 and bus_oe=0 throughout.
